lsu_mem_initiator: RTL

- Load/store initiator in the MEM stage; the requesting end of the data-memory interface.
- Accepts MemRead/MemWrite/Funct3/address/store data from the pipeline.
- Issues word-aligned, byte-enabled requests over a valid/ready channel and waits for the read response.
- Aligns and sign/zero-extends load data; stalls the pipeline until the access completes.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_load_align.sv | 15 +
 rtl/lsu_mem_initiator.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, Funct3 codes and lane helpers for the load/store initiator
package lsu_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size as an alignment mask: 0 byte, 1 half, 3 word.
    // Stores only know SB/SH and treat every other code as a word;
    // loads decode the size from the low two bits so LBU/LHU keep their size.
    function automatic logic [1:0] acc_size(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) ? 2'd0 : (f3 == F3_H) ? 2'd1 : 2'd3;
        return (f3[1:0] == 2'b00) ? 2'd0 : (f3[1:0] == 2'b01) ? 2'd1 : 2'd3;
    endfunction

    // Byte enables for a store at byte offset o.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] o);
        return (f3 == F3_B) ? (4'b0001 << o) :
               (f3 == F3_H) ? (4'b0011 << {o[1], 1'b0}) : 4'b1111;
    endfunction

    // Sign/zero extension of an already right-shifted load word.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] s);
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_BU:   return {24'h0, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_HU:   return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the read word down to the accessed lane and extends it
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data
);

    assign data = load_ext(funct3, rdata >> {offset, 3'b000});

endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: MEM-stage load/store initiator on a valid/ready memory channel.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS+1:0] addr,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd,
    output logic                  stall,
    output logic                  done,
    output logic                  misalign,
    output logic                  timeout,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [3:0]            mem_req_be,
    output logic [DM_ADDRESS-1:0] mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e                state_q, state_d;
    logic [DM_ADDRESS+1:0] addr_q, addr_d, addr_al;
    logic [2:0]            f3_q, f3_d;
    logic [DATA_W-1:0]     wd_q, wd_d, rd_q, rd_d, ld_data;
    logic                  we_q, we_d, mis_q, mis_d, to_q, to_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            sz;
    logic                  req;

    assign req     = MemRead | MemWrite;
    assign sz      = acc_size(!MemRead, Funct3);
    // Clearing the size-mask bits gives natural alignment; bytes are untouched.
    assign addr_al = {addr[DM_ADDRESS+1:2], addr[1:0] & ~sz};

    lsu_load_align #(.DATA_W(DATA_W)) u_align (
        .funct3 (f3_q),
        .offset (addr_q[1:0]),
        .rdata  (mem_rsp_rdata),
        .data   (ld_data)
    );

    // Access sequencing: capture in IDLE, handshake in REQ, response in WAIT, pulse in DONE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wd_d    = wd_q;
        we_d    = we_q;
        rd_d    = rd_q;
        mis_d   = mis_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr_al;
                    f3_d    = Funct3;
                    wd_d    = wd;
                    we_d    = !MemRead;
                    rd_d    = '0;
                    cnt_d   = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_d   = (sz == 2'd1 && addr[0]) || (sz == 2'd3 && addr[1:0] != 2'b00);
                    state_d = mis_d ? S_DONE : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ, S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (state_q == S_REQ && mem_req_ready) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end else if (state_q == S_WAIT && mem_rsp_valid) begin
                    rd_d    = ld_data;
                    state_d = S_DONE;
                end else if (cnt_d >= CNT_W'(TIMEOUT_CYC)) begin
                    to_d    = 1'b1;
                    rd_d    = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                mis_d   = 1'b0;
                to_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured access registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are zero whenever no request is on the channel.
    assign mem_req_valid = state_q == S_REQ;
    assign mem_req_we    = mem_req_valid & we_q;
    assign mem_req_be    = !mem_req_valid ? 4'b0000 : we_q ? store_be(f3_q, addr_q[1:0]) : 4'b1111;
    assign mem_req_addr  = mem_req_valid ? addr_q[DM_ADDRESS+1:2] : '0;
    assign mem_req_wdata = !mem_req_we ? '0 :
                           (f3_q == F3_B) ? {4{wd_q[7:0]}} :
                           (f3_q == F3_H) ? {2{wd_q[15:0]}} : wd_q;

    // Stall is forced low while reset is held so an aborted access releases the pipe at once.
    assign stall    = rst_n && (state_q == S_REQ || state_q == S_WAIT || (state_q == S_IDLE && req));
    assign done     = state_q == S_DONE;
    assign rd       = rd_q;
    assign misalign = mis_q;
    assign timeout  = to_q;

endmodule
